// File: rtl/axi_ddr_resp_model.sv
// rtl/axi_ddr_resp_model.sv - AXI4 memory responder standing in for external DDR
// One transaction at a time; reads return after a fixed latency from a word array.
module axi_ddr_resp_model #(
  parameter int    DATA_W     = 32,
  parameter int    ADDR_W     = 24,
  parameter int    ID_W       = 1,
  parameter int    MEM_ADDR_W = 16,
  parameter int    RD_LATENCY = 4,
  parameter string FILE       = "none"
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ID_W-1:0]   s_axi_awid,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic [7:0]        s_axi_awlen,
  input  logic [2:0]        s_axi_awsize,
  input  logic [1:0]        s_axi_awburst,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [DATA_W-1:0] s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  input  logic              s_axi_wlast,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [ID_W-1:0]   s_axi_bid,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [ID_W-1:0]   s_axi_arid,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic [7:0]        s_axi_arlen,
  input  logic [2:0]        s_axi_arsize,
  input  logic [1:0]        s_axi_arburst,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [ID_W-1:0]   s_axi_rid,
  output logic [DATA_W-1:0] s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rlast,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic              proto_err
);

  typedef enum logic [2:0] {IDLE, WR_DATA, WR_RESP, RD_LAT, RD_DATA} state_t;

  localparam logic [3:0] LAT_LOAD = 4'(RD_LATENCY - 1);

  logic [DATA_W-1:0] mem [0:(1<<MEM_ADDR_W)-1];

  state_t            state, state_n;
  logic              prio;
  logic [ID_W-1:0]   id_q;
  logic [ADDR_W-1:0] addr_q, addr_next;
  logic [7:0]        len_q;
  logic [2:0]        size_q;
  logic [1:0]        burst_q;
  logic [8:0]        beat;
  logic [3:0]        cnt;
  logic [DATA_W-1:0] rdata_q;
  logic              proto_q;
  logic              aw_fire, ar_fire, w_fire, r_fire, last_beat;

  assign last_beat = (beat == {1'b0, len_q});
  // FIXED holds the address; WRAP is deliberately treated as INCR
  assign addr_next = (burst_q == 2'b00) ? addr_q : addr_q + (ADDR_W'(1) << size_q);
  assign aw_fire   = s_axi_awvalid && s_axi_awready;
  assign ar_fire   = s_axi_arvalid && s_axi_arready;
  assign w_fire    = s_axi_wvalid && s_axi_wready;
  assign r_fire    = s_axi_rvalid && s_axi_rready;

  assign s_axi_bid   = id_q;
  assign s_axi_rid   = id_q;
  assign s_axi_bresp = 2'b00;
  assign s_axi_rresp = 2'b00;
  assign s_axi_rdata = rdata_q;
  assign proto_err   = proto_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (aw_fire) state_n = WR_DATA;
               else if (ar_fire) state_n = RD_LAT;
      WR_DATA: if (s_axi_wvalid && last_beat) state_n = WR_RESP;
      WR_RESP: if (s_axi_bready) state_n = IDLE;
      RD_LAT:  if (cnt == 4'd0) state_n = RD_DATA;
      RD_DATA: if (s_axi_rready && last_beat) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    s_axi_awready = 1'b0;
    s_axi_arready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    s_axi_rvalid  = 1'b0;
    s_axi_rlast   = 1'b0;
    case (state)
      IDLE: begin
        s_axi_awready = !reset && !(s_axi_arvalid && !prio);
        s_axi_arready = !reset && !(s_axi_awvalid && prio);
      end
      WR_DATA: s_axi_wready = 1'b1;
      WR_RESP: s_axi_bvalid = 1'b1;
      RD_DATA: begin
        s_axi_rvalid = 1'b1;
        s_axi_rlast  = last_beat;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_fire)
      for (int i = 0; i < 4; i++)
        if (s_axi_wstrb[i])
          mem[addr_q[MEM_ADDR_W+1:2]][8*i +: 8] <= s_axi_wdata[8*i +: 8];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio    <= 1'b0;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      beat    <= '0;
      cnt     <= '0;
      rdata_q <= '0;
      proto_q <= 1'b0;
    end else begin
      if (aw_fire || ar_fire) begin
        prio    <= ~prio;
        id_q    <= aw_fire ? s_axi_awid    : s_axi_arid;
        addr_q  <= aw_fire ? s_axi_awaddr  : s_axi_araddr;
        len_q   <= aw_fire ? s_axi_awlen   : s_axi_arlen;
        size_q  <= aw_fire ? s_axi_awsize  : s_axi_arsize;
        burst_q <= aw_fire ? s_axi_awburst : s_axi_arburst;
        beat    <= '0;
        cnt     <= LAT_LOAD;
      end
      if (w_fire) begin
        beat   <= beat + 9'd1;
        addr_q <= addr_next;
        if (s_axi_wlast != last_beat) proto_q <= 1'b1;
      end
      if (state == RD_LAT) begin
        if (cnt != 4'd0) cnt <= cnt - 4'd1;
        else             rdata_q <= mem[addr_q[MEM_ADDR_W+1:2]];
      end
      // Prefetch the next word on each accepted beat so beats stream without bubbles
      if (r_fire && !last_beat) begin
        beat    <= beat + 9'd1;
        addr_q  <= addr_next;
        rdata_q <= mem[addr_next[MEM_ADDR_W+1:2]];
      end
    end
  end

endmodule
